port_ingress_buf: RTL

Store-and-forward ingress buffer for one switch port; sits directly upstream of the port's SGDMA stage and drives its `i_dat`/`i_empty`/`i_sop`/`i_eop`/`i_rd_en` interface. Accepts a framed word stream from the port MAC side and stores each packet's data. Only when a packet completes does it build the header word {length, priority, dest_port}. Packets are presented to the SGDMA as header word followed by data words, so the SGDMA never sees a partial packet.

---
 rtl/port_ingress_buf_pkg.sv | 25 ++
 rtl/port_ingress_buf_hdr_fifo.sv | 41 ++++
 rtl/port_ingress_buf.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/port_ingress_buf_pkg.sv
// port_ingress_buf_pkg: header word layout and FSM encodings shared by the ingress buffer files.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package port_ingress_buf_pkg;
  localparam int HDR_W    = 18;
  localparam int LEN_MSB  = 17;
  localparam int LEN_LSB  = 7;
  localparam int PRIO_MSB = 6;
  localparam int PRIO_LSB = 4;
  localparam int DEST_MSB = 3;
  localparam int DEST_LSB = 0;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

  typedef enum logic {W_IDLE, W_PKT} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic [HDR_W-1:0] make_hdr(
    input logic [LEN_W-1:0] len,
    input logic [PRIO_MSB-PRIO_LSB:0] prio,
    input logic [DEST_MSB-DEST_LSB:0] dest
  );
    return {len, prio, dest};
  endfunction
endpackage

// File: rtl/port_ingress_buf_hdr_fifo.sv
// ingress_hdr_fifo: register FIFO of committed packet headers; the head entry is visible while count > 0.
module ingress_hdr_fifo
  import port_ingress_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = HDR_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_dat,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_dat,
  output logic [$clog2(DEPTH+1)-1:0]   o_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wp_q] <= i_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (i_push) wp_q <= wp_q + 1'b1;
      if (i_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_dat = mem_q[rp_q];
  assign o_cnt = cnt_q;
endmodule

// File: rtl/port_ingress_buf.sv
// port_ingress_buf: store-and-forward ingress buffer; only complete packets are presented
// to the SGDMA, as a header word {length, priority, dest} followed by the data words.
module port_ingress_buf
  import port_ingress_buf_pkg::*;
#(
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  parameter int DATA_DEPTH    = 512,
  parameter int HDR_DEPTH     = 16,
  parameter int MAX_PKT_WORDS = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_vld,
  input  logic                  i_wr_sop,
  input  logic                  i_wr_eop,
  input  logic [DATA_WIDTH-1:0] i_wr_dat,
  input  logic [2:0]            i_wr_prio,
  input  logic [3:0]            i_wr_dest,
  output logic                  o_wr_rdy,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic                  o_empty,
  output logic [15:0]           o_drop_cnt
);
  localparam int AW  = $clog2(DATA_DEPTH);
  localparam int CW  = $clog2(MAX_PKT_WORDS + 1);
  localparam int HCW = $clog2(HDR_DEPTH + 1);
  localparam int BPW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] ram [DATA_DEPTH];

  wr_state_e             wst_q, wst_d;
  logic [AW:0]           wptr_q, wptr_d, commit_q, commit_d, rptr_q;
  logic [CW-1:0]         wcnt_q, wcnt_d, hdr_words;
  logic                  swallow_q, swallow_d;
  logic [2:0]            prio_q, prio_d, hdr_prio;
  logic [3:0]            dest_q, dest_d, hdr_dest;
  logic [15:0]           drop_cnt_q;
  logic                  wr_acc, drop, push, ram_we;
  logic [AW-1:0]         ram_wa;
  logic [HDR_W-1:0]      hdr_in, hdr_out;
  logic [HCW-1:0]        hcnt;

  rd_state_e             rd_st_q;
  logic [CW-1:0]         remain_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  sop_q, eop_q, pop, rd_data;

  // Space is judged against the speculative pointer, so a packet in flight reserves its words.
  assign o_wr_rdy  = ((wptr_q - rptr_q) != (AW+1)'(DATA_DEPTH)) && (hcnt < HCW'(HDR_DEPTH));
  assign wr_acc    = i_wr_vld && o_wr_rdy;
  assign hdr_words = i_wr_sop ? CW'(1) : wcnt_q + 1'b1;
  assign hdr_prio  = i_wr_sop ? i_wr_prio : prio_q;
  assign hdr_dest  = i_wr_sop ? i_wr_dest : dest_q;
  assign hdr_in    = make_hdr(LEN_W'(hdr_words * BPW), hdr_prio, hdr_dest);

  always_comb begin
    wst_d     = wst_q;
    wptr_d    = wptr_q;
    commit_d  = commit_q;
    wcnt_d    = wcnt_q;
    swallow_d = swallow_q;
    prio_d    = prio_q;
    dest_d    = dest_q;
    drop      = 1'b0;
    push      = 1'b0;
    ram_we    = 1'b0;
    ram_wa    = wptr_q[AW-1:0];
    if (wr_acc && i_wr_sop) begin
      drop      = (wst_q == W_PKT) && !swallow_q;
      ram_we    = 1'b1;
      ram_wa    = commit_q[AW-1:0];
      wptr_d    = commit_q + 1'b1;
      wcnt_d    = CW'(1);
      swallow_d = 1'b0;
      prio_d    = i_wr_prio;
      dest_d    = i_wr_dest;
      push      = i_wr_eop;
      commit_d  = i_wr_eop ? commit_q + 1'b1 : commit_q;
      wst_d     = i_wr_eop ? W_IDLE : W_PKT;
    end else if (wr_acc && wst_q == W_PKT) begin
      if (swallow_q) begin
        swallow_d = !i_wr_eop;
        wst_d     = i_wr_eop ? W_IDLE : W_PKT;
      end else if (wcnt_q == CW'(MAX_PKT_WORDS)) begin
        drop      = 1'b1;
        wptr_d    = commit_q;
        swallow_d = !i_wr_eop;
        wst_d     = i_wr_eop ? W_IDLE : W_PKT;
      end else begin
        ram_we    = 1'b1;
        wptr_d    = wptr_q + 1'b1;
        wcnt_d    = wcnt_q + 1'b1;
        push      = i_wr_eop;
        commit_d  = i_wr_eop ? wptr_q + 1'b1 : commit_q;
        wst_d     = i_wr_eop ? W_IDLE : W_PKT;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (ram_we) ram[ram_wa] <= i_wr_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wst_q      <= W_IDLE;
      wptr_q     <= '0;
      commit_q   <= '0;
      wcnt_q     <= '0;
      swallow_q  <= 1'b0;
      prio_q     <= '0;
      dest_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      wst_q      <= wst_d;
      wptr_q     <= wptr_d;
      commit_q   <= commit_d;
      wcnt_q     <= wcnt_d;
      swallow_q  <= swallow_d;
      prio_q     <= prio_d;
      dest_q     <= dest_d;
      drop_cnt_q <= (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end
  end

  ingress_hdr_fifo #(
    .DEPTH (HDR_DEPTH),
    .W     (HDR_W)
  ) u_hdr_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_dat   (hdr_in),
    .i_pop   (pop),
    .o_dat   (hdr_out),
    .o_cnt   (hcnt)
  );

  assign o_empty = (rd_st_q == R_IDLE) && (hcnt == '0);
  assign pop     = i_rd_en && !o_empty && (rd_st_q == R_IDLE);
  assign rd_data = i_rd_en && (rd_st_q == R_DATA);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_st_q  <= R_IDLE;
      rptr_q   <= '0;
      remain_q <= '0;
      dat_q    <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      sop_q <= pop;
      eop_q <= rd_data && (remain_q == CW'(1));
      if (pop) begin
        dat_q    <= DATA_WIDTH'(hdr_out);
        remain_q <= CW'(hdr_out[LEN_MSB:LEN_LSB] / LEN_W'(BPW));
        rd_st_q  <= R_DATA;
      end else if (rd_data) begin
        dat_q    <= ram[rptr_q[AW-1:0]];
        rptr_q   <= rptr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
        rd_st_q  <= (remain_q == CW'(1)) ? R_IDLE : R_DATA;
      end
    end
  end

  assign o_dat      = dat_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_drop_cnt = drop_cnt_q;
endmodule
